// File: rtl/tri_viewport.sv
// Viewport stage: float32 NDC vertices -> clamped integer screen pixels,
// grouped three at a time into triangles on a valid/ready output.
module tri_viewport #(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720,
  parameter int X_CENTER   = 640,
  parameter int Y_CENTER   = 360,
  parameter int SCALE_LOG2 = 8,
  parameter int COORD_W    = 11
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [1:0][31:0]          coor_in,
  input  logic                      valid_in,
  input  logic                      frame_start_in,
  output logic [2:0][COORD_W-1:0]   tri_x_out,
  output logic [2:0][COORD_W-1:0]   tri_y_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      overflow_out
);

  localparam logic signed [17:0] X_MAX = 18'(H_RES - 1);
  localparam logic signed [17:0] Y_MAX = 18'(V_RES - 1);
  localparam logic signed [17:0] X_C   = 18'(X_CENTER);
  localparam logic signed [17:0] Y_C   = 18'(Y_CENTER);

  typedef enum logic [1:0] {
    V0 = 2'd0,
    V1 = 2'd1,
    V2 = 2'd2
  } vcnt_e;

  // Scaled float -> 16-bit signed integer, truncated toward zero, saturating.
  function automatic logic signed [15:0] f2i(input logic [31:0] f);
    logic [7:0]        e;
    logic signed [9:0] ex;
    logic [4:0]        sh;
    logic [15:0]       mag;
    e   = f[30:23];
    ex  = $signed({2'b00, e}) - 10'sd127 + $signed(10'(SCALE_LOG2));
    sh  = '0;
    mag = '0;
    if (e == 8'd0) begin
      mag = '0;
    end else if (e == 8'hff) begin
      mag = 16'd32767;
    end else if (ex < 10'sd0) begin
      mag = '0;
    end else if (ex >= 10'sd15) begin
      mag = 16'd32767;
    end else begin
      sh  = 5'(10'sd23 - ex);
      mag = 16'({1'b1, f[22:0]} >> sh);
    end
    return $signed(f[31] ? 16'(-mag) : mag);
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input logic signed [17:0] v,
                                               input logic signed [17:0] hi);
    if (v < 18'sd0)
      return '0;
    else if (v > hi)
      return COORD_W'(hi);
    else
      return COORD_W'(v);
  endfunction

  logic                            s1_valid;
  logic signed [15:0]              s1_x, s1_y;
  logic                            s2_valid;
  logic [COORD_W-1:0]              s2_x, s2_y;
  logic [2:0][COORD_W-1:0]         stage_x, stage_y;
  logic                            tri_done;
  vcnt_e                           vcnt, vcnt_nxt;

  logic signed [15:0]              xi_nxt, yi_nxt;
  logic signed [17:0]              px, py;
  logic                            s2_take;
  logic                            tri_complete;
  logic                            out_free;

  always_comb begin
    xi_nxt = f2i(coor_in[1]);
    yi_nxt = f2i(coor_in[0]);
    px     = X_C + 18'(s1_x);
    py     = Y_C - 18'(s1_y);
  end

  // frame_start discards whatever vertex reaches the assembler this cycle.
  always_comb begin
    s2_take      = s2_valid && !frame_start_in;
    tri_complete = s2_take && (vcnt == V2);
    out_free     = !valid_out || ready_in;
    vcnt_nxt     = vcnt;
    if (frame_start_in) begin
      vcnt_nxt = V0;
    end else if (s2_valid) begin
      case (vcnt)
        V0:      vcnt_nxt = V1;
        V1:      vcnt_nxt = V2;
        default: vcnt_nxt = V0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      vcnt <= V0;
    else
      vcnt <= vcnt_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_x <= xi_nxt;
        s1_y <= yi_nxt;
      end
      s2_valid <= s1_valid && !frame_start_in;
      if (s1_valid) begin
        s2_x <= clamp(px, X_MAX);
        s2_y <= clamp(py, Y_MAX);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stage_x  <= '0;
      stage_y  <= '0;
      tri_done <= 1'b0;
    end else begin
      tri_done <= tri_complete;
      if (s2_take) begin
        case (vcnt)
          V0: begin
            stage_x[0] <= s2_x;
            stage_y[0] <= s2_y;
          end
          V1: begin
            stage_x[1] <= s2_x;
            stage_y[1] <= s2_y;
          end
          default: begin
            stage_x[2] <= s2_x;
            stage_y[2] <= s2_y;
          end
        endcase
      end
    end
  end

  // Loading reads staging before the next triangle's vertex 0 overwrites slot 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tri_x_out    <= '0;
      tri_y_out    <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (tri_done && out_free) begin
        tri_x_out <= stage_x;
        tri_y_out <= stage_y;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      if (tri_done && !out_free)
        overflow_out <= 1'b1;
    end
  end

endmodule
